// File: rtl/cic_out_norm.sv
// Normalises the full-precision CIC output (round half up, shift by ORDER*os_sel, saturate to OW)
// and buffers it in a small valid/ready FIFO. Define CIC_OUT_NORM_STATS_EN for sat_cnt/drop_cnt.
module cic_out_norm #(
  parameter int ORDER  = 4,
  parameter int MAX_OS = 7,
  parameter int OW     = 16,
  parameter int IW     = OW + ORDER * MAX_OS,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             os_sel,
  input  logic                   in_valid,
  input  logic [IW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   clr_flags
`ifdef CIC_OUT_NORM_STATS_EN
  ,
  output logic [15:0]            sat_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int SHW = $clog2(ORDER * MAX_OS + 1);
  localparam logic signed [IW:0] SAT_MAX = {{(IW - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [IW:0] SAT_MIN = {{(IW - OW + 2){1'b1}}, {(OW - 1){1'b0}}};
  localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW - 1){1'b1}}};
  localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW - 1){1'b0}}};

  logic [2:0]              os_sel_q, os_sel_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [IW-1:0]    s1_data_q, s1_data_d;
  logic [SHW-1:0]          s1_sh_q, s1_sh_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [IW:0]      s2_data_q, s2_data_d;
  logic [OW-1:0]           mem_q [DEPTH];
  logic [OW-1:0]           mem_d [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    sat_flag_q, sat_flag_d, ovf_flag_q, ovf_flag_d;
  logic                    flush, clip_hi, clip_lo, clip_ev;
  logic                    pop, push_req, full, push, drop;
  logic signed [IW:0]      rnd, sum;
  logic [OW-1:0]           sat_data;
`ifdef CIC_OUT_NORM_STATS_EN
  logic [15:0]             sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    // A change of os_sel invalidates everything in flight, including this cycle's input.
    flush      = (os_sel != os_sel_q);
    os_sel_d   = os_sel;
    s1_valid_d = in_valid & ~flush;
    s1_data_d  = in_data;
    s1_sh_d    = SHW'(ORDER * int'(os_sel));

    if (s1_sh_q != {SHW{1'b0}}) begin
      rnd = {{IW{1'b0}}, 1'b1} << (s1_sh_q - SHW'(1));
    end else begin
      rnd = {(IW + 1){1'b0}};
    end
    sum        = {s1_data_q[IW-1], s1_data_q} + rnd;
    s2_valid_d = s1_valid_q & ~flush;
    s2_data_d  = sum >>> s1_sh_q;

    clip_hi = (s2_data_q > SAT_MAX);
    clip_lo = (s2_data_q < SAT_MIN);
    if (clip_hi) begin
      sat_data = OUT_MAX;
    end else if (clip_lo) begin
      sat_data = OUT_MIN;
    end else begin
      sat_data = s2_data_q[OW-1:0];
    end

    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != {LW{1'b0}}) & out_ready;
    push_req = s2_valid_q & ~flush;
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    clip_ev  = push_req & (clip_hi | clip_lo);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = sat_data;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d = flush ? {AW{1'b0}} : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
    rd_ptr_d = flush ? {AW{1'b0}} : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
    level_d  = flush ? {LW{1'b0}} : (level_q + LW'(push) - LW'(pop));

    sat_flag_d = clr_flags ? 1'b0 : (sat_flag_q | clip_ev);
    ovf_flag_d = clr_flags ? 1'b0 : (ovf_flag_q | drop);
`ifdef CIC_OUT_NORM_STATS_EN
    if (clr_flags) begin
      sat_cnt_d  = 16'h0000;
      drop_cnt_d = 16'h0000;
    end else begin
      sat_cnt_d  = (clip_ev && sat_cnt_q != 16'hFFFF) ? sat_cnt_q + 16'h0001 : sat_cnt_q;
      drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'h0001 : drop_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      os_sel_q   <= os_sel;
      s1_valid_q <= 1'b0;
      s1_data_q  <= {IW{1'b0}};
      s1_sh_q    <= {SHW{1'b0}};
      s2_valid_q <= 1'b0;
      s2_data_q  <= {(IW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {OW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      sat_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
`ifdef CIC_OUT_NORM_STATS_EN
      sat_cnt_q  <= 16'h0000;
      drop_cnt_q <= 16'h0000;
`endif
    end else begin
      os_sel_q   <= os_sel_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sh_q    <= s1_sh_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sat_flag_q <= sat_flag_d;
      ovf_flag_q <= ovf_flag_d;
`ifdef CIC_OUT_NORM_STATS_EN
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  assign out_valid  = (level_q != {LW{1'b0}});
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign sat_flag   = sat_flag_q;
  assign ovf_flag   = ovf_flag_q;
`ifdef CIC_OUT_NORM_STATS_EN
  assign sat_cnt    = sat_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cic_out_norm.sv
// Bench for cic_out_norm: directed literal checks plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_cic_out_norm;
  localparam int ORDER = 4;
  localparam int MAX_OS = 7;
  localparam int OW = 16;
  localparam int IW = OW + ORDER * MAX_OS;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset_n, in_valid, out_ready, clr_flags, out_valid, sat_flag, ovf_flag;
  logic [2:0] os_sel;
  logic [IW-1:0] in_data;
  logic [OW-1:0] out_data;
  logic [LW-1:0] fifo_level;
`ifdef CIC_OUT_NORM_STATS_EN
  logic [15:0] sat_cnt, drop_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cic_out_norm #(.ORDER(ORDER), .MAX_OS(MAX_OS), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .os_sel(os_sel), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level),
    .sat_flag(sat_flag), .ovf_flag(ovf_flag), .clr_flags(clr_flags)
`ifdef CIC_OUT_NORM_STATS_EN
    , .sat_cnt(sat_cnt), .drop_cnt(drop_cnt)
`endif
  );

  // Reference: two samples in flight (already normalised), then a bounded queue.
  int m_fifo[$];
  bit p_v[2];
  int p_val[2];
  bit p_clip[2];
  bit m_sat, m_ovf;
  logic [2:0] m_os;
  int m_satc, m_dropc;

  function automatic int norm(input longint x, input int os, output bit clip);
    longint y;
    int sh;
    sh = ORDER * os;
    y = x;
    if (sh > 0) y = (x + (longint'(1) << (sh - 1))) >>> sh;
    clip = (y > 32767) || (y < -32768);
    if (y > 32767) return 32767;
    else if (y < -32768) return -32768;
    else return int'(y);
  endfunction

  task automatic model_step();
    bit pop, accept, c;
    if (!reset_n) begin
      m_fifo.delete();
      p_v[0] = 1'b0; p_v[1] = 1'b0;
      m_sat = 1'b0; m_ovf = 1'b0; m_satc = 0; m_dropc = 0;
      m_os = os_sel;
    end else if (os_sel != m_os) begin
      m_fifo.delete();
      p_v[0] = 1'b0; p_v[1] = 1'b0;
      m_os = os_sel;
    end else begin
      pop = (m_fifo.size() > 0) && out_ready;
      accept = 1'b0;
      if (p_v[1]) begin
        if (p_clip[1]) begin
          m_sat = 1'b1;
          if (m_satc < 65535) m_satc++;
        end
        if (m_fifo.size() < DEPTH || pop) accept = 1'b1;
        else begin
          m_ovf = 1'b1;
          if (m_dropc < 65535) m_dropc++;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (accept) m_fifo.push_back(p_val[1]);
      p_v[1] = p_v[0]; p_val[1] = p_val[0]; p_clip[1] = p_clip[0];
      p_v[0] = in_valid;
      p_val[0] = norm(longint'($signed(in_data)), int'(os_sel), c);
      p_clip[0] = c;
    end
    if (reset_n && clr_flags) begin
      m_sat = 1'b0; m_ovf = 1'b0; m_satc = 0; m_dropc = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    int h;
    logic [15:0] e;
    chk("m_out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
    chk("m_fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
    chk("m_sat_flag", 64'(sat_flag), 64'(m_sat));
    chk("m_ovf_flag", 64'(ovf_flag), 64'(m_ovf));
    if (m_fifo.size() != 0) begin
      h = m_fifo[0];
      e = h[15:0];
      chk("m_out_data", 64'(out_data), 64'(e));
    end
`ifdef CIC_OUT_NORM_STATS_EN
    chk("m_sat_cnt", 64'(sat_cnt), 64'(m_satc));
    chk("m_drop_cnt", 64'(drop_cnt), 64'(m_dropc));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input longint v);
    in_valid = 1'b1;
    in_data = IW'(v);
    tick();
    in_valid = 1'b0;
    in_data = {IW{1'b0}};
  endtask

  initial begin
    longint x;
    reset_n = 1'b0; os_sel = 3'd0; in_valid = 1'b0; in_data = {IW{1'b0}};
    out_ready = 1'b1; clr_flags = 1'b0;
    wait_n(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    chk("rst_ovf", 64'(ovf_flag), 64'd0);
    reset_n = 1'b1;

    // rounding
    os_sel = 3'd1; wait_n(2);
    drive(24); wait_n(2);
    chk("round_pos_valid", 64'(out_valid), 64'd1);
    chk("round_pos", 64'(out_data), 64'd2);
    chk("round_pos_sat", 64'(sat_flag), 64'd0);
    wait_n(1);
    drive(-24); wait_n(2);
    chk("round_neg", 64'(out_data), 64'hFFFF);
    wait_n(1);
    drive(-8); wait_n(2);
    chk("round_tie_valid", 64'(out_valid), 64'd1);
    chk("round_tie", 64'(out_data), 64'd0);
    wait_n(1);

    // saturation and flag clear
    os_sel = 3'd0; wait_n(2);
    drive(40000); wait_n(2);
    chk("sat_pos", 64'(out_data), 64'h7FFF);
    chk("sat_flag_set", 64'(sat_flag), 64'd1);
    wait_n(1);
    drive(-40000); wait_n(2);
    chk("sat_neg", 64'(out_data), 64'h8000);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("sat_flag_clr", 64'(sat_flag), 64'd0);

    // overflow
    out_ready = 1'b0; wait_n(1);
    for (int v = 1; v <= 5; v++) drive(longint'(v));
    wait_n(2);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag", 64'(ovf_flag), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_data", 64'(out_data), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;

    // flush on os_sel change, same-cycle sample discarded
    os_sel = 3'd1; wait_n(2);
    out_ready = 1'b0;
    drive(16); drive(32); drive(48); wait_n(2);
    chk("flush_pre_level", 64'(fifo_level), 64'd3);
    os_sel = 3'd2; in_valid = 1'b1; in_data = IW'(64'd4096);
    tick();
    in_valid = 1'b0; in_data = {IW{1'b0}};
    chk("flush_level", 64'(fifo_level), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1; wait_n(2);
    chk("flush_discard", 64'(fifo_level), 64'd0);
    drive(256); wait_n(2);
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_data", 64'(out_data), 64'd1);
    wait_n(1);

    // reset mid-stream
    os_sel = 3'd0; wait_n(2);
    drive(100); drive(200);
    reset_n = 1'b0; tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    reset_n = 1'b1; wait_n(4);
    chk("no_stale", 64'(out_valid), 64'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      x = {$urandom(), $urandom()};
      x = x >>> $urandom_range(8, 50);
      in_data = IW'(x);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_flags = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) os_sel = 3'($urandom_range(0, 7));
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1; in_valid = 1'b0; clr_flags = 1'b0; out_ready = 1'b1;
    wait_n(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cic_out_norm.md
Name: cic_out_norm

Overview:
- Downstream stage of cic_filter. Takes the full-precision decimated CIC output and removes the bit growth selected by os_sel, with rounding and saturation to the output width.
- Decouples the fixed-rate CIC output from the consumer through a small valid/ready FIFO, because the CIC cannot be back-pressured.
- Single clock. The decimated rate appears as an in_valid strobe (the clk_div pulse), not a second clock.

Parameters:
- ORDER, 4, number of CIC integrator/comb stages; bit growth = ORDER*os_sel.
- MAX_OS, 7, maximum os_sel value (decimation 2^os_sel).
- OW, 16, output sample width.
- IW, OW+ORDER*MAX_OS (44), input sample width, signed.
- DEPTH, 4, output FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- os_sel  in  3  oversampling select; shift = ORDER*os_sel.
- in_valid  in  1  one-cycle strobe; in_data valid this cycle.
- in_data  in  IW  signed CIC output sample.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  OW  signed normalized sample, FIFO head.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sat_flag  out  1  sticky: at least one sample was clipped.
- ovf_flag  out  1  sticky: at least one sample was dropped because the FIFO was full.
- clr_flags  in  1  clears sat_flag and ovf_flag; takes priority over a same-cycle set.

Behaviour:
- Reset (reset_n=0 at posedge clk): pipeline valids 0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, sat_flag=0, ovf_flag=0, os_sel_q=os_sel.
- Pipeline is 3 stages and never stalls.
  - S1: register in_data and sh=ORDER*os_sel.
  - S2: if sh>0, add 2^(sh-1) (round half up) in IW+1 bits, then arithmetic shift right by sh.
  - S3: saturate to [-2^(OW-1), 2^(OW-1)-1], then write the FIFO.
- Latency: a sample taken at edge k is written at edge k+2. With the FIFO empty, out_valid=1 and out_data are valid in the cycle after edge k+2.
- os_sel=0: sh=0, no rounding; saturate only.
- sat_flag sets at the S3 edge when clipping occurs.
- FIFO push and pop:
  - Pop when out_valid && out_ready.
  - Push when S3 is valid and (level<DEPTH or a pop happens the same cycle).
  - Push and pop together leave level unchanged.
- FIFO full with no pop: the S3 sample is dropped and ovf_flag sets. Stored contents are untouched.
- out_data holds its value while out_valid=1 and out_ready=0. Data is FIFO order, no reordering.
- os_sel change (os_sel != os_sel_q) flushes the block:
  - Clears all pipeline valids and empties the FIFO at that edge.
  - The in_valid sample in the same cycle is discarded.
  - os_sel_q updates.
  - Flags are unaffected.
- Reset asserted mid-stream: everything returns to reset values at that edge; in-flight samples are lost.
- in_valid strobes closer together than one clock are impossible. Back-to-back strobes every cycle (os_sel=0) must be sustained with out_ready=1.

Optional Feature:
- Macro CIC_OUT_NORM_STATS_EN.
- Defined: adds output sat_cnt[15:0] and output drop_cnt[15:0].
  - sat_cnt counts clipped samples; drop_cnt counts dropped samples.
  - Both stick at 0xFFFF rather than wrapping.
  - Both clear on reset and on clr_flags.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Rounding, positive: ORDER=4, os_sel=1, out_ready=1, in_data=24 at edge k -> out_data=2 ((24+8)>>4), out_valid in the cycle after edge k+2, sat_flag=0.
- Rounding, negative and tie: os_sel=1, in_data=-24 -> -1; in_data=-8 -> 0.
- Saturation: os_sel=0, in_data=40000 -> 32767; in_data=-40000 -> -32768; sat_flag=1. clr_flags=1 -> sat_flag=0 next cycle.
- Overflow: os_sel=0, out_ready=0, in_data=1,2,3,4,5 on consecutive cycles -> fifo_level=4, ovf_flag=1. Then out_ready=1 -> outputs 1,2,3,4, then out_valid=0.
- Flush: 3 samples queued, os_sel changes 1->2 -> next cycle fifo_level=0, out_valid=0. A new sample of 16*16=256 -> out_data=1.
- Reset mid-stream: reset_n=0 for 1 cycle with 2 samples in flight -> all outputs at reset values, no stale sample emerges.
